// File: rtl/prince_cms_pkg.sv
// Shared constants for the first-order CMS-masked PRINCE S-box pipeline.
// The ANF masks are derived from the S-box table so the two cannot drift apart.
package prince_cms_pkg;

  localparam int NIB_W       = 4;
  localparam int NCOMP       = 16;
  localparam int LANE_RND_W  = 64;
  localparam int LANE_COMP_W = NIB_W * NCOMP;

  // Nibble i of the table is S(i), S(0) in the least significant nibble.
  localparam logic [63:0] SBOX_TABLE = 64'h4D5E_0876_19CA_23FB;

  function automatic logic [3:0] sbox4(input logic [3:0] a);
    return SBOX_TABLE[{a, 2'b00} +: 4];
  endfunction

  // Bit m of the result is the ANF coefficient of monomial m (bit3=x .. bit0=w)
  function automatic logic [15:0] anf_mask(input int b);
    logic [15:0] mask;
    logic [3:0]  m4;
    logic [3:0]  u4;
    logic [3:0]  nib;
    mask = 16'h0000;
    for (int m = 0; m < 16; m++) begin
      m4 = m[3:0];
      for (int u = 0; u < 16; u++) begin
        u4  = u[3:0];
        nib = sbox4(u4);
        if ((u4 & ~m4) == 4'b0000) begin
          mask[m] = mask[m] ^ nib[b];
        end else begin
          mask[m] = mask[m];
        end
      end
    end
    return mask;
  endfunction

  localparam logic [3:0][15:0] ANF_MASK = {anf_mask(3), anf_mask(2), anf_mask(1), anf_mask(0)};

  function automatic logic [3:0] unmask4(input logic [3:0] a, input logic [3:0] b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/prince_sbox_cms_comp.sv
// One masked S-box lane: expands each output bit into 16 non-complete
// component shares and ring-refreshes them. Purely combinational.
module prince_sbox_cms_comp
  import prince_cms_pkg::*;
(
  input  logic [3:0]  sh0,
  input  logic [3:0]  sh1,
  input  logic [63:0] rnd,
  output logic [63:0] comp
);

  logic [3:0] sel_s;
  logic [3:0] vars_s;
  logic [3:0] mon_s;
  logic       f_s;

  // Component s picks share s[v] of each variable; variables outside a monomial are forced to 1.
  always_comb begin
    comp   = 64'h0;
    sel_s  = 4'b0000;
    vars_s = 4'b0000;
    mon_s  = 4'b0000;
    f_s    = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < 16; s++) begin
        sel_s  = s[3:0];
        vars_s = (sel_s & sh1) | (~sel_s & sh0);
        f_s    = 1'b0;
        for (int m = 0; m < 16; m++) begin
          mon_s = m[3:0];
          if (ANF_MASK[b][m] && ((sel_s & ~mon_s) == 4'b0000)) begin
            f_s = f_s ^ (&(vars_s | ~mon_s));
          end else begin
            f_s = f_s;
          end
        end
        comp[16*b+s] = f_s ^ rnd[16*b+s] ^ rnd[16*b+((s+1)%16)];
      end
    end
  end

endmodule

// File: rtl/prince_sbox_cms_pipe.sv
// Two-stage CMS-masked PRINCE S-box: registered refreshed components, then
// registered compression to two shares, with valid/ready on both sides.
module prince_sbox_cms_pipe
  import prince_cms_pkg::*;
#(
  parameter int NLANE = 1,
  parameter int RND_W = 64 * NLANE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NIB_W*NLANE-1:0] in_sh0,
  input  logic [NIB_W*NLANE-1:0] in_sh1,
  input  logic [RND_W-1:0]       rnd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NIB_W*NLANE-1:0] out_sh0,
  output logic [NIB_W*NLANE-1:0] out_sh1
);

  localparam int DW = NIB_W * NLANE;
  localparam int CW = LANE_COMP_W * NLANE;

  logic [CW-1:0] comp_s;
  logic [CW-1:0] comp_r;
  logic [DW-1:0] cmp0_s;
  logic [DW-1:0] cmp1_s;
  logic [DW-1:0] sh0_r;
  logic [DW-1:0] sh1_r;
  logic          v1_r;
  logic          v2_r;
  logic          load1_s;
  logic          load2_s;

  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    prince_sbox_cms_comp u_comp (
      .sh0  (in_sh0[NIB_W*l +: NIB_W]),
      .sh1  (in_sh1[NIB_W*l +: NIB_W]),
      .rnd  (rnd[LANE_RND_W*l +: LANE_RND_W]),
      .comp (comp_s[LANE_COMP_W*l +: LANE_COMP_W])
    );
  end

  // Pipeline advance conditions; stage 1 may load whenever stage 2 frees up.
  always_comb begin
    load2_s = 1'b0;
    load1_s = 1'b0;
    load2_s = !v2_r || out_ready;
    load1_s = !v1_r || load2_s;
  end

  assign in_ready = load1_s;

  // Compress registered components: sx=0 half forms share 0, sx=1 half share 1.
  always_comb begin
    cmp0_s = '0;
    cmp1_s = '0;
    for (int l = 0; l < NLANE; l++) begin
      for (int b = 0; b < NIB_W; b++) begin
        cmp0_s[NIB_W*l+b] = ^comp_r[LANE_COMP_W*l + 16*b +: 8];
        cmp1_s[NIB_W*l+b] = ^comp_r[LANE_COMP_W*l + 16*b + 8 +: 8];
      end
    end
  end

  // Stage 1: refreshed component register; data only captured on a real transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r   <= 1'b0;
      comp_r <= '0;
    end else if (load1_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        comp_r <= comp_s;
      end else begin
        comp_r <= comp_r;
      end
    end else begin
      v1_r   <= v1_r;
      comp_r <= comp_r;
    end
  end

  // Stage 2: compressed output shares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r  <= 1'b0;
      sh0_r <= '0;
      sh1_r <= '0;
    end else if (load2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        sh0_r <= cmp0_s;
        sh1_r <= cmp1_s;
      end else begin
        sh0_r <= sh0_r;
        sh1_r <= sh1_r;
      end
    end else begin
      v2_r  <= v2_r;
      sh0_r <= sh0_r;
      sh1_r <= sh1_r;
    end
  end

  assign out_valid = v2_r;
  assign out_sh0   = sh0_r;
  assign out_sh1   = sh1_r;

endmodule

// File: tb/tb_prince_sbox_cms_pipe.sv
// Directed self-checking bench for the masked PRINCE S-box pipeline (4 lanes)
// plus a structural share-dependence probe on a single component lane.
module tb_prince_sbox_cms_pipe;
  import prince_cms_pkg::*;

  localparam int NL = 4;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [4*NL-1:0] in_sh0;
  logic [4*NL-1:0] in_sh1;
  logic [64*NL-1:0] rnd;
  logic            out_valid;
  logic            out_ready;
  logic [4*NL-1:0] out_sh0;
  logic [4*NL-1:0] out_sh1;

  logic [3:0]  p_sh0;
  logic [3:0]  p_sh1;
  logic [63:0] p_rnd;
  logic [63:0] p_comp;

  int n_checks;
  int n_errors;

  logic [4*NL-1:0]  it0 [0:255];
  logic [4*NL-1:0]  it1 [0:255];
  logic [64*NL-1:0] itr [0:255];

  prince_sbox_cms_pipe #(.NLANE(NL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sh0    (in_sh0),
    .in_sh1    (in_sh1),
    .rnd       (rnd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sh0   (out_sh0),
    .out_sh1   (out_sh1)
  );

  prince_sbox_cms_comp u_probe (
    .sh0  (p_sh0),
    .sh1  (p_sh1),
    .rnd  (p_rnd),
    .comp (p_comp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] sref(input logic [3:0] a);
    logic [63:0] t;
    t = 64'h4D5E_0876_19CA_23FB;
    return t[4*a +: 4];
  endfunction

  function automatic logic [4*NL-1:0] exp_unm(input logic [4*NL-1:0] a, input logic [4*NL-1:0] b);
    logic [4*NL-1:0] res;
    for (int l = 0; l < NL; l++) res[4*l +: 4] = sref(a[4*l +: 4] ^ b[4*l +: 4]);
    return res;
  endfunction

  // Share 0 equals S evaluated with x taken from share 0 only, masked by r_0^r_8.
  function automatic logic [4*NL-1:0] exp_sh0(input logic [4*NL-1:0] a, input logic [4*NL-1:0] b,
                                               input logic [64*NL-1:0] r);
    logic [4*NL-1:0] res;
    logic [3:0] u;
    logic [3:0] rm;
    for (int l = 0; l < NL; l++) begin
      u = a[4*l +: 4] ^ b[4*l +: 4];
      for (int k = 0; k < 4; k++) rm[k] = r[64*l + 16*k] ^ r[64*l + 16*k + 8];
      res[4*l +: 4] = sref({a[4*l+3], u[2:0]}) ^ rm;
    end
    return res;
  endfunction

  function automatic logic [64*NL-1:0] rand_rnd();
    logic [64*NL-1:0] v;
    for (int i = 0; i < 2*NL; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sh0 = '0; in_sh1 = '0; rnd = '0;
    p_sh0 = 4'h0; p_sh1 = 4'h0; p_rnd = 64'h0;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_sh0 !== 16'h0) begin n_errors++; $display("FAIL reset_out_sh0: got %h expected 0000", out_sh0); end
    n_checks++; if (out_sh1 !== 16'h0) begin n_errors++; $display("FAIL reset_out_sh1: got %h expected 0000", out_sh1); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive();
    logic [7:0]  kk;
    logic [15:0] tmp;
    logic        exp_v;
    int          idx;
    for (int k = 0; k < 256; k++) begin
      kk = 8'(k);
      tmp = 16'($urandom()); it0[k] = {tmp[15:4], kk[7:4]};
      tmp = 16'($urandom()); it1[k] = {tmp[15:4], kk[3:0]};
      itr[k] = rand_rnd();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 259; c++) begin
      if (c < 256) begin
        in_valid = 1'b1; in_sh0 = it0[c]; in_sh1 = it1[c]; rnd = itr[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_v = (c >= 2) && (c < 258);
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL exh_in_ready c=%0d: got %b expected 1", c, in_ready); end
      n_checks++; if (out_valid !== exp_v) begin n_errors++; $display("FAIL exh_out_valid c=%0d: got %b expected %b", c, out_valid, exp_v); end
      if (exp_v) begin
        idx = c - 2;
        n_checks++; if (out_sh0 !== exp_sh0(it0[idx], it1[idx], itr[idx])) begin n_errors++;
          $display("FAIL exh_sh0 item=%0d: got %h expected %h", idx, out_sh0, exp_sh0(it0[idx], it1[idx], itr[idx])); end
        n_checks++; if ((out_sh0 ^ out_sh1) !== exp_unm(it0[idx], it1[idx])) begin n_errors++;
          $display("FAIL exh_unmask item=%0d: got %h expected %h", idx, out_sh0 ^ out_sh1, exp_unm(it0[idx], it1[idx])); end
        if (idx == 8'hAF) begin
          n_checks++; if (unmask4(out_sh0[3:0], out_sh1[3:0]) !== 4'hC) begin n_errors++;
            $display("FAIL exh_a_f: got %h expected c", unmask4(out_sh0[3:0], out_sh1[3:0])); end
        end
        if (idx == 0) begin
          n_checks++; if (unmask4(out_sh0[3:0], out_sh1[3:0]) !== 4'hB) begin n_errors++;
            $display("FAIL exh_0_0: got %h expected b", unmask4(out_sh0[3:0], out_sh1[3:0])); end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rnd_independence();
    logic [15:0] first0;
    logic        varied;
    logic        exp_v;
    int          idx;
    for (int k = 0; k < 8; k++) begin
      it0[k] = 16'h3333; it1[k] = 16'h0000; itr[k] = rand_rnd();
    end
    it0[8] = 16'h0000; it1[8] = 16'h0000; itr[8] = '0;
    varied = 1'b0; first0 = 16'h0000;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 9) begin
        in_valid = 1'b1; in_sh0 = it0[c]; in_sh1 = it1[c]; rnd = itr[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_v = (c >= 2) && (c < 11);
      n_checks++; if (out_valid !== exp_v) begin n_errors++; $display("FAIL rnd_out_valid c=%0d: got %b expected %b", c, out_valid, exp_v); end
      if (exp_v) begin
        idx = c - 2;
        n_checks++; if ((out_sh0 ^ out_sh1) !== ((idx < 8) ? 16'h2222 : 16'hBBBB)) begin n_errors++;
          $display("FAIL rnd_unmask item=%0d: got %h expected %h", idx, out_sh0 ^ out_sh1, (idx < 8) ? 16'h2222 : 16'hBBBB); end
        n_checks++; if (out_sh0 !== exp_sh0(it0[idx], it1[idx], itr[idx])) begin n_errors++;
          $display("FAIL rnd_sh0 item=%0d: got %h expected %h", idx, out_sh0, exp_sh0(it0[idx], it1[idx], itr[idx])); end
        if (idx == 0) first0 = out_sh0;
        else if (idx < 8 && out_sh0 !== first0) varied = 1'b1;
      end
      @(posedge clk); #1;
    end
    n_checks++; if (varied !== 1'b1) begin n_errors++; $display("FAIL rnd_sh0_varies: got %b expected 1", varied); end
  endtask

  task automatic test_backpressure();
    logic [15:0]  q0 [$];
    logic [15:0]  q1 [$];
    logic [255:0] qr [$];
    logic         exp_rdy;
    int sent;
    int got;
    int cyc;
    for (int k = 0; k < 10; k++) begin
      it0[k] = 16'($urandom()); it1[k] = 16'($urandom()); itr[k] = rand_rnd();
    end
    sent = 0; got = 0; cyc = 0;
    while (got < 10 && cyc < 200) begin
      out_ready = (cyc >= 2) && (cyc % 2 == 0);
      if (sent < 10) begin
        in_valid = 1'b1; in_sh0 = it0[sent]; in_sh1 = it1[sent]; rnd = itr[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_rdy = !((q0.size() == 2) && !out_ready);
      n_checks++; if (in_ready !== exp_rdy) begin n_errors++; $display("FAIL bp_in_ready cyc=%0d: got %b expected %b", cyc, in_ready, exp_rdy); end
      if (out_valid && out_ready) begin
        if (q0.size() == 0) begin
          n_checks++; n_errors++; $display("FAIL bp_extra_output cyc=%0d: got %h expected none", cyc, out_sh0);
        end else begin
          n_checks++; if (out_sh0 !== exp_sh0(q0[0], q1[0], qr[0])) begin n_errors++;
            $display("FAIL bp_sh0 out=%0d: got %h expected %h", got, out_sh0, exp_sh0(q0[0], q1[0], qr[0])); end
          n_checks++; if ((out_sh0 ^ out_sh1) !== exp_unm(q0[0], q1[0])) begin n_errors++;
            $display("FAIL bp_unmask out=%0d: got %h expected %h", got, out_sh0 ^ out_sh1, exp_unm(q0[0], q1[0])); end
          void'(q0.pop_front()); void'(q1.pop_front()); void'(qr.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q0.push_back(in_sh0); q1.push_back(in_sh1); qr.push_back(rnd); sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++; if (got != 10) begin n_errors++; $display("FAIL bp_outputs: got %0d expected 10", got); end
    n_checks++; if (sent != 10) begin n_errors++; $display("FAIL bp_rnd_consumed: got %0d expected 10", sent); end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic exp_v;
    it0[0] = 16'h1234; it1[0] = 16'hFEDC; itr[0] = rand_rnd();
    it0[1] = 16'h5A5A; it1[1] = 16'h0F0F; itr[1] = rand_rnd();
    it0[2] = 16'h9C3E; it1[2] = 16'h47B1; itr[2] = rand_rnd();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_sh0 = it0[c]; in_sh1 = it1[c]; rnd = itr[c];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rm_full_before: got %b expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rm_out_valid: got %b expected 0", out_valid); end
    n_checks++; if ({out_sh0, out_sh1} !== 32'h0) begin n_errors++; $display("FAIL rm_out_sh: got %h expected 00000000", {out_sh0, out_sh1}); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rm_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = (c == 0); in_sh0 = it0[2]; in_sh1 = it1[2]; rnd = itr[2];
      #1;
      exp_v = (c == 2);
      n_checks++; if (out_valid !== exp_v) begin n_errors++; $display("FAIL rm_after_valid c=%0d: got %b expected %b", c, out_valid, exp_v); end
      if (exp_v) begin
        n_checks++; if ((out_sh0 ^ out_sh1) !== exp_unm(it0[2], it1[2])) begin n_errors++;
          $display("FAIL rm_after_unmask: got %h expected %h", out_sh0 ^ out_sh1, exp_unm(it0[2], it1[2])); end
        n_checks++; if (out_sh0 !== exp_sh0(it0[2], it1[2], itr[2])) begin n_errors++;
          $display("FAIL rm_after_sh0: got %h expected %h", out_sh0, exp_sh0(it0[2], it1[2], itr[2])); end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_probing();
    logic [63:0] base;
    logic [63:0] keep;
    logic [3:0]  sv;
    logic [3:0]  sum;
    logic [3:0]  sref_v;
    for (int p = 0; p < 3; p++) begin
      p_sh0 = 4'($urandom()); p_sh1 = 4'($urandom()); p_rnd = {$urandom(), $urandom()};
      #1;
      base = p_comp;
      for (int b = 0; b < 4; b++) sum[b] = ^base[16*b +: 16];
      sref_v = sref(p_sh0 ^ p_sh1);
      n_checks++; if (sum !== sref_v) begin n_errors++; $display("FAIL probe_sum p=%0d: got %h expected %h", p, sum, sref_v); end
      for (int v = 0; v < 4; v++) begin
        for (int j = 0; j < 2; j++) begin
          for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < 16; s++) begin
              sv = 4'(s);
              keep[16*b+s] = (sv[v] != 1'(j));
            end
          end
          if (j == 0) p_sh0[v] = ~p_sh0[v]; else p_sh1[v] = ~p_sh1[v];
          #1;
          n_checks++; if (((p_comp ^ base) & keep) !== 64'h0) begin n_errors++;
            $display("FAIL probe_dep v=%0d share=%0d: got %h expected 0", v, j, (p_comp ^ base) & keep); end
          if (j == 0) p_sh0[v] = ~p_sh0[v]; else p_sh1[v] = ~p_sh1[v];
          #1;
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_exhaustive();
    test_rnd_independence();
    test_backpressure();
    test_reset_mid();
    test_probing();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prince_sbox_cms_pipe.md
Name: prince_sbox_cms_pipe

Overview:
Parametrised, pipelined, first-order CMS-masked PRINCE 4-bit S-box with NLANE parallel lanes. Each lane takes a 2-share nibble, expands every output bit into 16 non-complete component shares, and ring-refreshes them with fresh randomness into a register stage. A second stage compresses the components back to 2 shares. Valid/ready handshakes on both sides let it sit inside the masked PRINCE round datapath with backpressure.

Parameters:
NLANE, 1, number of parallel 4-bit S-box lanes
RND_W, 64*NLANE, fresh random bits per accepted input (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input shares and randomness valid
in_ready  output  1  stage 1 can accept this cycle
in_sh0  input  4*NLANE  share 0, lane L at bits [4L+3:4L], bit3=x, bit2=y, bit1=z, bit0=w
in_sh1  input  4*NLANE  share 1, same packing
rnd  input  RND_W  fresh randomness, sampled with the input
out_valid  output  1  output shares valid
out_ready  input  1  consumer accepts output
out_sh0  output  4*NLANE  output share 0
out_sh1  output  4*NLANE  output share 1

Behaviour:
- Function: per lane, out_sh0^out_sh1 = S(in_sh0^in_sh1), S = {B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4} (index 0..F). Each output bit is a cubic ANF in x,y,z,w.
- Component shares: for output bit b, component index s = (sx,sy,sz,sw) in 0..15, sx is the MSB. Component f_b,s evaluates each ANF monomial of bit b on shares x_sx, y_sy, z_sz, w_sw. A monomial is included in f_b,s only if every variable absent from it has share index 0 in s. The constant term is included only in s=0. Each component therefore reads exactly one share per variable.
- Refresh: c_b,s = f_b,s ^ r_b,s ^ r_b,(s+1 mod 16). Lane L, bit b, component s uses rnd bit 64L+16b+s.
- Stage 1 registers 16 components per bit per lane, plus v1. Stage 2 registers the compressed shares plus v2.
- Compression: out_sh0 bit = XOR of components s=0..7. out_sh1 bit = XOR of components s=8..15.
- No combinational path from in_sh*/rnd to out_sh*. Unregistered recombination of shares is forbidden.
- Handshake:
  - Stage 2 loads when !v2 or out_ready.
  - Stage 1 loads when !v1 or stage 2 loads.
  - in_ready = !v1 | !v2 | out_ready.
  - Transfer occurs on in_valid & in_ready. rnd is consumed only on that transfer.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle while out_ready=1.
- Stall: with out_ready=0 and both stages full, in_ready=0 and all registers hold. Data and randomness are neither lost nor duplicated.
- Simultaneous: when out_ready=1 and the pipe is full, an input transfer and an output transfer happen in the same cycle.
- in_valid=0 while the stage loads: v1 clears. Stage-1 data regs may hold their old value, since v gates them.
- Reset (async, rst_n=0): v1=v2=0; all share/component regs=0; out_valid=0, out_sh0=out_sh1=0. in_ready=1 during and after reset.
- Reset mid-operation drops in-flight items. The first output after reset comes from the first post-reset input.
- Outputs are valid-qualified; out_sh* may change only on a stage-2 load.

Decomposition:
- Package prince_cms_pkg:
  - S-box table constant.
  - Per-bit ANF monomial masks (4-bit variable-set vectors), from which the component functions are generated.
  - Lane/share packing widths.
  - Function unmask4 for benches.
- Sub-module prince_sbox_cms_comp: one lane, combinational.
  - Inputs: 2 shares plus 64 rnd bits.
  - Outputs: 64 refreshed components.
  - Instantiated NLANE times.
  - Pipeline registers and handshake stay in the top.

Test Plan:
- Exhaustive: NLANE=1, all 256 (sh0,sh1) pairs, rnd random, out_ready=1 -> each output unmasks to S(sh0^sh1), e.g. sh0=A, sh1=F -> unmask C; 0/0 -> B; out_valid exactly 2 cycles after each transfer.
- Randomness independence: fixed input sh0=3, sh1=0, varying rnd -> unmasked output always 2, out_sh0 varies; rnd=0 with input 0/0 -> out_sh0^out_sh1=B.
- Backpressure: NLANE=4, stream 10 inputs, out_ready toggled 0,0,1,0,1,... -> in_ready=0 only when v1&v2&!out_ready; outputs in order, no loss or duplication; rnd consumed exactly 10 times.
- Full-throughput: continuous in_valid, out_ready=1 -> one result per cycle after 2-cycle fill; lane L of input k unmasks to S of its nibble.
- Reset mid-operation: two items in flight, assert rst_n=0 for 1 cycle -> out_valid=0 and out_sh*=0 immediately (async); in_ready=1; next input appears after 2 cycles with the correct value.
- Probing aid: bench checks each stage-1 component depends on at most one share of each variable (structural check via the per-lane comp module).
